// File: rtl/taiko_pkg.sv
// Shared chart-entry encoding and chart sequencer FSM state encoding.
package taiko_pkg;

    localparam logic [1:0] NOTE_REST = 2'b00;
    localparam logic [1:0] NOTE_DO   = 2'b01;
    localparam logic [1:0] NOTE_KA   = 2'b10;
    localparam logic [1:0] NOTE_END  = 2'b11;

    localparam int NOTE_TYPE_MSB = 15;
    localparam int NOTE_TYPE_LSB = 14;
    localparam int NOTE_WAIT_W   = 14;
    localparam int NOTE_CNT_W    = 10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEAD,
        ST_FETCH,
        ST_LOAD,
        ST_HOLD,
        ST_DONE
    } note_state_e;

    function automatic logic is_note(input logic [1:0] t);
        return (t == NOTE_DO) || (t == NOTE_KA);
    endfunction

endpackage

// File: rtl/note_chart_seq_if.sv
// Chart sequencer bundle: frame/control inputs, chart ROM port and note-request outputs.
interface note_chart_seq_if #(parameter int ADDR_W = 10);

    logic              vsync;
    logic              start;
    logic              pause;
    logic [ADDR_W-1:0] rom_addr;
    logic [15:0]       rom_data;
    logic [1:0]        request;
    logic              playing;
    logic              done;
    logic [9:0]        note_cnt;

    modport master (
        input  vsync, start, pause, rom_data,
        output rom_addr, request, playing, done, note_cnt
    );

    modport slave (
        output vsync, start, pause, rom_data,
        input  rom_addr, request, playing, done, note_cnt
    );

endinterface

// File: rtl/note_frame_timer.sv
// Loadable 14-bit frame countdown shared by the lead-in and per-entry waits.
module note_frame_timer import taiko_pkg::*; (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   load,
    input  logic [NOTE_WAIT_W-1:0] value,
    input  logic                   tick,
    output logic                   zero,
    output logic                   fire
);

    logic [NOTE_WAIT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst_n)
            cnt <= '0;
        else if (load)
            cnt <= value;
        else if (tick && (cnt != '0))
            cnt <= cnt - NOTE_WAIT_W'(1);
    end

    assign zero = (cnt == '0);
    assign fire = tick & zero;

endmodule

// File: rtl/note_chart_seq.sv
// Chart sequencer: walks the chart ROM and emits {ka, do} requests on frame ticks.
// NOTE_CHART_LOOP_EN: an end entry restarts the chart from address 0 instead of stopping.
module note_chart_seq import taiko_pkg::*; #(
    parameter int ADDR_W      = 10,
    parameter int LEAD_FRAMES = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    note_chart_seq_if.master bus
);

    localparam logic [NOTE_WAIT_W-1:0] LEAD_LOAD =
        (LEAD_FRAMES > 0) ? NOTE_WAIT_W'(LEAD_FRAMES - 1) : '0;

    note_state_e            state_q, state_nx;
    logic [ADDR_W-1:0]      addr_q, addr_nx;
    logic [1:0]             req_q, req_nx;
    logic [1:0]             type_q, type_nx;
    logic [1:0]             pend_q, pend_nx;
    logic                   playing_q, playing_nx;
    logic                   done_q, done_nx;
    logic [NOTE_CNT_W-1:0]  cnt_q, cnt_nx;
    logic                   tick, hold_tick;
    logic                   tmr_load, tmr_tick, tmr_zero, tmr_fire;
    logic [NOTE_WAIT_W-1:0] tmr_val;

    note_frame_timer u_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (tmr_load),
        .value (tmr_val),
        .tick  (tmr_tick),
        .zero  (tmr_zero),
        .fire  (tmr_fire)
    );

    assign tick      = bus.vsync & ~bus.pause;
    assign hold_tick = tick | (pend_q != 2'd0);

    always_comb begin
        state_nx   = state_q;
        addr_nx    = addr_q;
        req_nx     = req_q;
        type_nx    = type_q;
        pend_nx    = pend_q;
        playing_nx = playing_q;
        done_nx    = done_q;
        cnt_nx     = cnt_q;
        tmr_load   = 1'b0;
        tmr_tick   = 1'b0;
        tmr_val    = bus.rom_data[NOTE_WAIT_W-1:0];

        if (bus.vsync)
            req_nx = NOTE_REST;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (bus.start) begin
                    addr_nx    = '0;
                    done_nx    = 1'b0;
                    playing_nx = 1'b1;
                    cnt_nx     = '0;
                    pend_nx    = 2'd0;
                    tmr_load   = 1'b1;
                    tmr_val    = LEAD_LOAD;
                    state_nx   = (LEAD_FRAMES == 0) ? ST_FETCH : ST_LEAD;
                end
            end
            ST_LEAD: begin
                tmr_tick = tick;
                if (tmr_fire)
                    state_nx = ST_FETCH;
            end
            ST_FETCH: begin
                if (tick && (pend_q != 2'd3))
                    pend_nx = pend_q + 2'd1;
                state_nx = ST_LOAD;
            end
            ST_LOAD: begin
                if (tick && (pend_q != 2'd3))
                    pend_nx = pend_q + 2'd1;
                type_nx = bus.rom_data[NOTE_TYPE_MSB:NOTE_TYPE_LSB];
                if (type_nx == NOTE_END) begin
`ifdef NOTE_CHART_LOOP_EN
                    addr_nx  = '0;
                    state_nx = ST_FETCH;
`else
                    playing_nx = 1'b0;
                    done_nx    = 1'b1;
                    state_nx   = ST_DONE;
`endif
                end else begin
                    tmr_load = 1'b1;
                    state_nx = ST_HOLD;
                end
            end
            ST_HOLD: begin
                // A tick latched during FETCH/LOAD is consumed here, one per cycle.
                tmr_tick = hold_tick;
                if ((pend_q != 2'd0) && !tick)
                    pend_nx = pend_q - 2'd1;
                if (hold_tick && tmr_zero) begin
                    req_nx   = type_q;
                    addr_nx  = addr_q + ADDR_W'(1);
                    state_nx = ST_FETCH;
                    if (is_note(type_q) && (cnt_q != '1))
                        cnt_nx = cnt_q + NOTE_CNT_W'(1);
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            addr_q    <= '0;
            req_q     <= NOTE_REST;
            type_q    <= NOTE_REST;
            pend_q    <= 2'd0;
            playing_q <= 1'b0;
            done_q    <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_nx;
            addr_q    <= addr_nx;
            req_q     <= req_nx;
            type_q    <= type_nx;
            pend_q    <= pend_nx;
            playing_q <= playing_nx;
            done_q    <= done_nx;
            cnt_q     <= cnt_nx;
        end
    end

    assign bus.rom_addr = addr_q;
    assign bus.request  = req_q;
    assign bus.playing  = playing_q;
    assign bus.done     = done_q;
    assign bus.note_cnt = cnt_q;

endmodule

// File: tb/tb_note_chart_seq.sv
// Scoreboard bench for note_chart_seq: expected consumer samples queued per vsync, checked by monitors.
module tb_note_chart_seq;

    logic clk = 1'b0;
    logic rst_n;
    logic vsync, start, pause;

    note_chart_seq_if #(.ADDR_W(10)) bus0 ();
    note_chart_seq_if #(.ADDR_W(10)) bus1 ();

    assign bus0.vsync = vsync;
    assign bus0.start = start;
    assign bus0.pause = pause;
    assign bus1.vsync = vsync;
    assign bus1.start = start;
    assign bus1.pause = pause;

    note_chart_seq #(.ADDR_W(10), .LEAD_FRAMES(0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
    note_chart_seq #(.ADDR_W(10), .LEAD_FRAMES(2)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

    always #5 clk = ~clk;

    logic [15:0] rom [0:15];
    always_ff @(posedge clk) begin
        bus0.rom_data <= rom[bus0.rom_addr[3:0]];
        bus1.rom_data <= rom[bus1.rom_addr[3:0]];
    end

    int n_checks = 0;
    int n_pass   = 0;
    logic [1:0] q0[$];
    logic [1:0] q1[$];
    logic [1:0] last0, last1;
    logic       chk1 = 1'b0;
    int         gap  = 7;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    // Consumer view: on each vsync the request set at the previous frame is sampled.
    always @(negedge clk) begin
        if (vsync) begin
            if (q0.size() == 0) chk("sb0_underflow", 1, 0);
            else chk("sb0_request", int'(bus0.request), int'(q0.pop_front()));
        end
    end

    always @(negedge clk) begin
        if (vsync && chk1) begin
            if (q1.size() == 0) chk("sb1_underflow", 1, 0);
            else chk("sb1_request", int'(bus1.request), int'(q1.pop_front()));
        end
    end

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic vs(input logic [1:0] e0, input logic [1:0] e1, input logic p);
        q0.push_back(last0);
        if (chk1) q1.push_back(last1);
        pause = p;
        vsync = 1'b1;
        tick();
        vsync = 1'b0;
        repeat (gap) tick();
        last0 = e0;
        last1 = e1;
    endtask

    task automatic load_rom(input logic [15:0] a, input logic [15:0] b, input logic [15:0] c);
        for (int i = 0; i < 16; i++) rom[i] = 16'hC000;
        rom[0] = a;
        rom[1] = b;
        rom[2] = c;
    endtask

    task automatic pulse_start(input int idle);
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (idle) tick();
    endtask

    initial begin
        logic got;
        rst_n = 1'b0; vsync = 1'b0; start = 1'b0; pause = 1'b0;
        last0 = 2'b00; last1 = 2'b00;
        load_rom(16'hC000, 16'hC000, 16'hC000);
        tick(); tick();
        chk("rst_request",  int'(bus0.request), 0);
        chk("rst_playing",  int'(bus0.playing), 0);
        chk("rst_done",     int'(bus0.done), 0);
        chk("rst_note_cnt", int'(bus0.note_cnt), 0);
        chk("rst_rom_addr", int'(bus0.rom_addr), 0);
        rst_n = 1'b1;
        tick();

`ifdef NOTE_CHART_LOOP_EN
        load_rom({2'b01, 14'd0}, 16'hC000, 16'hC000);
        pulse_start(3);
        chk("loop_playing0", int'(bus0.playing), 1);
        for (int i = 0; i < 4; i++) vs(2'b01, 2'b00, 1'b0);
        vs(2'b01, 2'b00, 1'b0);
        chk("loop_done",     int'(bus0.done), 0);
        chk("loop_playing",  int'(bus0.playing), 1);
        chk("loop_note_cnt", int'(bus0.note_cnt), 5);
`else
        // Basic chart; dut1 runs the same chart with a two-frame lead-in.
        load_rom({2'b01, 14'd0}, {2'b10, 14'd2}, 16'hC000);
        chk1 = 1'b1;
        pulse_start(3);
        chk("t1_playing", int'(bus0.playing), 1);
        vs(2'b01, 2'b00, 1'b0);
        vs(2'b00, 2'b00, 1'b0);
        vs(2'b00, 2'b01, 1'b0);
        vs(2'b10, 2'b00, 1'b0);
        vs(2'b00, 2'b00, 1'b0);
        vs(2'b00, 2'b10, 1'b0);
        vs(2'b00, 2'b00, 1'b0);
        chk1 = 1'b0;
        chk("t1_done",      int'(bus0.done), 1);
        chk("t1_playing_e", int'(bus0.playing), 0);
        chk("t1_note_cnt",  int'(bus0.note_cnt), 2);
        chk("t1_lead_done", int'(bus1.done), 1);
        chk("t1_lead_cnt",  int'(bus1.note_cnt), 2);

        // Start one cycle before vsync: the tick is latched and applied in HOLD.
        load_rom({2'b01, 14'd0}, 16'hC000, 16'hC000);
        start = 1'b1;
        tick();
        start = 1'b0;
        q0.push_back(last0);
        vsync = 1'b1;
        tick();
        vsync = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 3 && !got; i++) begin
            tick();
            if (bus0.request == 2'b01) got = 1'b1;
        end
        chk("pend_fire", int'(got), 1);
        repeat (6) tick();
        last0 = 2'b01;
        vs(2'b00, 2'b00, 1'b0);
        chk("pend_note_cnt", int'(bus0.note_cnt), 1);
        chk("pend_done",     int'(bus0.done), 1);

        // Pause over vsyncs 2..6 during a wait of 3: do fires on vsync 9.
        load_rom({2'b01, 14'd3}, 16'hC000, 16'hC000);
        pulse_start(3);
        vs(2'b00, 2'b00, 1'b0);
        for (int i = 0; i < 5; i++) vs(2'b00, 2'b00, 1'b1);
        vs(2'b00, 2'b00, 1'b0);
        vs(2'b00, 2'b00, 1'b0);
        chk("pause_cnt_pre", int'(bus0.note_cnt), 0);
        vs(2'b01, 2'b00, 1'b0);
        vs(2'b00, 2'b00, 1'b0);
        chk("pause_note_cnt", int'(bus0.note_cnt), 1);

        // Longest rest then a zero-wait ka: ka fires on vsync 16385.
        load_rom({2'b00, 14'd16383}, {2'b10, 14'd0}, 16'hC000);
        gap = 2;
        pulse_start(3);
        for (int i = 0; i < 16384; i++) vs(2'b00, 2'b00, 1'b0);
        chk("rest_cnt_pre", int'(bus0.note_cnt), 0);
        vs(2'b10, 2'b00, 1'b0);
        vs(2'b00, 2'b00, 1'b0);
        chk("rest_note_cnt", int'(bus0.note_cnt), 1);
        chk("rest_done",     int'(bus0.done), 1);
        gap = 7;

        // Reset while holding request=10, then replay from address 0.
        load_rom({2'b10, 14'd0}, {2'b01, 14'd5}, 16'hC000);
        pulse_start(3);
        vs(2'b10, 2'b00, 1'b0);
        tick();
        chk("mid_request_pre", int'(bus0.request), 2);
        rst_n = 1'b0;
        tick();
        chk("mid_request",  int'(bus0.request), 0);
        chk("mid_playing",  int'(bus0.playing), 0);
        chk("mid_done",     int'(bus0.done), 0);
        chk("mid_note_cnt", int'(bus0.note_cnt), 0);
        chk("mid_rom_addr", int'(bus0.rom_addr), 0);
        rst_n = 1'b1;
        last0 = 2'b00;
        tick();
        pulse_start(3);
        vs(2'b10, 2'b00, 1'b0);
        chk("replay_rom_addr", int'(bus0.rom_addr), 1);
        vs(2'b00, 2'b00, 1'b0);
        chk("replay_note_cnt", int'(bus0.note_cnt), 1);
`endif

        chk("sb0_drained", q0.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/note_chart_seq.md
# note_chart_seq

Chart sequencer that is the producer side of the note-request interface consumed by the do/ka note queues. It walks a chart stored in a synchronous block ROM and counts frames on the one-pulsed vsync tick. At the right frame it drives the `{ka, do}` request pair, replacing the free-running fixed-interval note generator in the game top level. It sits between the chart ROM and the note queue logic, in the 100 MHz `clk` domain.

## Interface
- `ADDR_W`, 10: chart ROM address width (up to 1024 entries).
- `LEAD_FRAMES`, 4: frames waited after `start` before the first entry's wait begins.
- `clk` in 1: system clock (100 MHz).
- `rst_n` in 1: reset; one clock, synchronous, active-low.
- `vsync` in 1: one-cycle frame tick (one-pulsed vsync), about 60 Hz.
- `start` in 1: one-cycle pulse; begins playback from address 0.
- `pause` in 1: level; freezes frame counting while high.
- `rom_addr` out ADDR_W: chart ROM read address.
- `rom_data` in 16: chart entry, valid one cycle after `rom_addr`.
- `request` out 2: `{ka_request, do_request}`; updated only on vsync cycles.
- `playing` out 1: high from the `start` acceptance until end-of-chart.
- `done` out 1: high once end-of-chart is reached; cleared by the next `start`.
- `note_cnt` out 10: number of do/ka requests emitted, saturating at 1023.

## Operation
- Entry format:
  - `[15:14]` type: 00 rest, 01 do, 10 ka, 11 end.
  - `[13:0]` wait, in frames.
- Event timing: an entry's event fires on the (wait+1)-th counted vsync after the previous event, or after the lead-in ends.
- Rest entries emit nothing. They exist to build waits longer than 16383 frames.
- FSM states: IDLE, LEAD, FETCH, LOAD, HOLD, DONE.
- IDLE/DONE, on `start`:
  - `rom_addr` is cleared to 0.
  - `done` is cleared, `playing` is set and `note_cnt` is cleared.
  - If `LEAD_FRAMES` = 0 the FSM goes to FETCH, otherwise to LEAD.
- LEAD: counts `LEAD_FRAMES` counted vsyncs, then goes to FETCH.
- FETCH: `rom_addr` is stable for one cycle, then the FSM goes to LOAD.
- LOAD: captures `rom_data`.
  - If type = end, the FSM goes to DONE with `playing`=0 and `done`=1.
  - Otherwise the countdown is loaded with wait and the FSM goes to HOLD.
- HOLD, on each counted vsync:
  - If countdown > 0, decrement it.
  - If countdown = 0, fire the event: `request` takes 01 (do), 10 (ka) or 00 (rest), `rom_addr` increments, the FSM goes to FETCH, and `note_cnt` increments on do/ka only.
- `request` on every vsync cycle that does not fire an event is 00. Any value is therefore held exactly one frame, which is exactly one consumer sample.
- Counted vsync: `vsync`=1 and `pause`=0. While paused, `request` is forced to 00 at each vsync.
- `rom_addr` reaching its maximum value without an end entry wraps to 0. Chart authors are responsible for terminating the chart.
- `start` while `playing` is ignored.

## Timing
- Reset values: `request`=0, `playing`=0, `done`=0, `note_cnt`=0, `rom_addr`=0, state IDLE.
- Fetch latency: 2 cycles (FETCH, LOAD).
- Vsync during FETCH/LOAD: a vsync arriving here (e.g. `start` one cycle before vsync) is latched in a pending flag. It is applied on the first HOLD cycle with identical effect, except that `request` updates on that cycle instead of the vsync cycle. Ticks are never lost.
- Consumer sampling: the consumer samples `request` on a vsync cycle. A request set at frame N's vsync is consumed at frame N+1.
- Reset mid-play: `rst_n`=0 returns everything to reset values on the next edge, and `request` drops that cycle.
- Saturation: `note_cnt` holds at 1023.

## Configuration
- `NOTE_CHART_LOOP_EN` defined: an end entry resets `rom_addr` to 0 and goes to FETCH. `playing` stays 1, `done` never asserts, and `note_cnt` keeps counting with saturation.
- Undefined: an end entry terminates playback into DONE, as described above.

## Structure
- Shared package `taiko_pkg`:
  - Entry type codes (`NOTE_REST`, `NOTE_DO`, `NOTE_KA`, `NOTE_END`).
  - Field positions and widths (`NOTE_TYPE_MSB/LSB`, `NOTE_WAIT_W`=14).
  - The FSM state encoding.
- Sub-module `note_frame_timer`: a loadable 14-bit countdown.
  - Inputs: `load`, `value`, `tick`.
  - Outputs: `zero`, `fire`.
  - Used for both the LEAD count and the HOLD wait.

## Test plan
- ROM {do w0, ka w2, end}, `LEAD_FRAMES`=0, `start`:
  - `request`=01 on vsync 1 after start, 00 on vsync 2–3, 10 on vsync 4.
  - Then `done`=1, `playing`=0, `note_cnt`=2.
- `start` asserted one cycle before a vsync:
  - The pending tick is applied.
  - A w0 do fires within 3 cycles of that vsync, and no vsync is lost.
- `pause` high for 5 vsyncs during a w3 wait: the do fires on the 4th counted vsync, which is the 9th vsync overall.
- Rest w16383 followed by ka w0: `request` stays 00 throughout, ka fires at vsync 16385, and `note_cnt`=1.
- `rst_n` low mid-HOLD with `request`=10: all outputs are 0 the next cycle, and a following `start` replays from address 0.
- With `NOTE_CHART_LOOP_EN`, ROM {do w0, end}:
  - `request`=01 on vsyncs 1, 2, 3 and onward, since each end entry costs no frame.
  - `done` stays 0.
